mips_mem_arbiter: RTL and testbench

Single-port memory arbiter for the MIPS32 core. It shares one unified instruction/data memory between three requesters: the program loader port (LD), the MEM-stage data port (DM, for LW/SW), and the IF-stage fetch port (IF). Arbitration uses fixed priority with an IF starvation guard. Every granted access is acknowledged exactly one cycle after issue.

---
 rtl/mips_mem_arbiter.sv | 110 +++++++++++
 tb/tb_mips_mem_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter shared by the loader, MEM-stage data and IF fetch ports.
// Fixed priority LD > DM > IF, with IF promoted to the top after STARVE_LIMIT denied cycles.
module mips_mem_arbiter #(
  parameter int unsigned AW           = 10,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {GntNone, GntLd, GntDm, GntIf} gnt_e;

  gnt_e       gnt_q, gnt_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       ld_elig, dm_elig, if_elig;

  // A requester whose ack is arriving this cycle is masked so it is not granted twice.
  assign ld_elig = ld_req && (gnt_q != GntLd);
  assign dm_elig = dm_req && (gnt_q != GntDm);
  assign if_elig = if_req && (gnt_q != GntIf);

  always_comb begin
    gnt_d        = GntNone;
    starve_cnt_d = starve_cnt_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    if (rst) begin
      gnt_d = GntNone;
    end else if (if_elig && (starve_cnt_q == Limit)) begin
      gnt_d = GntIf;
    end else if (ld_elig) begin
      gnt_d = GntLd;
    end else if (dm_elig) begin
      gnt_d = GntDm;
    end else if (if_elig) begin
      gnt_d = GntIf;
    end

    unique case (gnt_d)
      GntLd: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      GntDm: begin
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      GntIf: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      default: ;
    endcase

    if (gnt_d == GntIf) begin
      starve_cnt_d = 4'd0;
    end else if (if_elig && (starve_cnt_q != Limit)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      gnt_q        <= GntNone;
      starve_cnt_q <= 4'd0;
    end else begin
      gnt_q        <= gnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Reset kills an ack that is in flight; the requester still holds req and reissues.
  assign ld_ack   = !rst && (gnt_q == GntLd);
  assign dm_ack   = !rst && (gnt_q == GntDm);
  assign if_ack   = !rst && (gnt_q == GntIf);
  assign dm_rdata = mem_rdata;
  assign if_rdata = mem_rdata;
  assign busy     = ld_req || dm_req || if_req || (gnt_q != GntNone);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomized bench for mips_mem_arbiter: a behavioural memory plus a rule-level
// arbitration model and a shadow memory to predict every strobe, ack and read value.
module tb_mips_mem_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
  localparam int NCYC  = 3000;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          ld_req, dm_req, dm_we, if_req;
  logic [AW-1:0] ld_addr, dm_addr, if_addr;
  logic [DW-1:0] ld_wdata, dm_wdata;
  logic [DW-1:0] dm_rdata, if_rdata, mem_wdata, mem_rdata;
  logic          ld_ack, dm_ack, if_ack, mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;

  mips_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk1     (clk1),
    .rst      (rst),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .ld_ack   (ld_ack),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clk1 = ~clk1;

  // Environment memory with a registered read port.
  logic [DW-1:0] env_mem [1 << AW];
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: 0 none, 1 LD, 2 DM, 3 IF.
  logic [DW-1:0] model_mem [1 << AW];
  int            m_gnt, m_starve;
  logic          m_dm_rd;
  logic [DW-1:0] m_dm_exp, m_if_exp;

  initial begin
    int win;
    bit el [4];
    int order [3];
    bit e_ld_ack, e_dm_ack, e_if_ack, e_we;
    int pct_ld, pct_dm, pct_if;
    logic          n_rst, n_ld_req, n_dm_req, n_dm_we, n_if_req;
    logic [AW-1:0] n_ld_addr, n_dm_addr, n_if_addr;
    logic [DW-1:0] n_ld_wdata, n_dm_wdata;

    for (int i = 0; i < (1 << AW); i++) begin
      env_mem[i]   = 32'h28010078 + 32'(i) * 32'h01010101;
      model_mem[i] = 32'h28010078 + 32'(i) * 32'h01010101;
    end
    mem_rdata = '0;
    rst = 1'b1; ld_req = 1'b0; dm_req = 1'b0; if_req = 1'b0; dm_we = 1'b0;
    ld_addr = '0; dm_addr = '0; if_addr = '0; ld_wdata = '0; dm_wdata = '0;
    m_gnt = 0; m_starve = 0; m_dm_rd = 1'b0; m_dm_exp = '0; m_if_exp = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk1);
      // Phases alternate saturating traffic (forces starvation) and sparse traffic.
      case ((cyc / 300) % 3)
        0:       begin pct_ld = 100; pct_dm = 100; pct_if = 100; end
        1:       begin pct_ld = 10;  pct_dm = 50;  pct_if = 80;  end
        default: begin pct_ld = 0;   pct_dm = 100; pct_if = 100; end
      endcase

      el[0] = 1'b0;
      el[1] = ld_req && (m_gnt != 1);
      el[2] = dm_req && (m_gnt != 2);
      el[3] = if_req && (m_gnt != 3);
      order = '{1, 2, 3};
      win = 0;
      if (!rst) begin
        if (el[3] && m_starve == LIMIT) win = 3;
        else foreach (order[k]) if (win == 0 && el[order[k]]) win = order[k];
      end
      e_ld_ack = !rst && m_gnt == 1;
      e_dm_ack = !rst && m_gnt == 2;
      e_if_ack = !rst && m_gnt == 3;
      e_we = (win == 1) || (win == 2 && dm_we);

      check("mem_en", 64'(mem_en), 64'(win != 0));
      check("mem_we", 64'(mem_we), 64'(e_we));
      if (win == 1) check("mem_addr_ld", 64'(mem_addr), 64'(ld_addr));
      if (win == 2) check("mem_addr_dm", 64'(mem_addr), 64'(dm_addr));
      if (win == 3) check("mem_addr_if", 64'(mem_addr), 64'(if_addr));
      if (win == 1) check("mem_wdata_ld", 64'(mem_wdata), 64'(ld_wdata));
      if (win == 2 && dm_we) check("mem_wdata_dm", 64'(mem_wdata), 64'(dm_wdata));
      check("ld_ack", 64'(ld_ack), 64'(e_ld_ack));
      check("dm_ack", 64'(dm_ack), 64'(e_dm_ack));
      check("if_ack", 64'(if_ack), 64'(e_if_ack));
      check("busy", 64'(busy), 64'(ld_req || dm_req || if_req || m_gnt != 0));
      if (e_dm_ack && m_dm_rd) check("dm_rdata", 64'(dm_rdata), 64'(m_dm_exp));
      if (e_if_ack) check("if_rdata", 64'(if_rdata), 64'(m_if_exp));

      // Advance the model.
      case (win)
        1: model_mem[ld_addr] = ld_wdata;
        2: begin
          m_dm_rd = !dm_we;
          if (dm_we) model_mem[dm_addr] = dm_wdata;
          else       m_dm_exp = model_mem[dm_addr];
        end
        3: m_if_exp = model_mem[if_addr];
        default: ;
      endcase
      if (rst || win == 3) m_starve = 0;
      else if (el[3] && m_starve < LIMIT) m_starve++;
      m_gnt = rst ? 0 : win;

      // Requesters hold until acked, then may issue anew from the following cycle.
      n_rst = (cyc < 3) || (cyc > 10 && $urandom_range(149) == 0);
      n_ld_req = ld_req; n_ld_addr = ld_addr; n_ld_wdata = ld_wdata;
      n_dm_req = dm_req; n_dm_addr = dm_addr; n_dm_wdata = dm_wdata; n_dm_we = dm_we;
      n_if_req = if_req; n_if_addr = if_addr;
      if (e_ld_ack) n_ld_req = 1'b0;
      if (e_dm_ack) n_dm_req = 1'b0;
      if (e_if_ack) begin n_if_req = 1'b0; n_if_addr = if_addr + 1'b1; end
      if (cyc >= 2) begin
        if (!ld_req && !n_ld_req && $urandom_range(99) < pct_ld) begin
          n_ld_req = 1'b1; n_ld_addr = AW'($urandom_range(15)); n_ld_wdata = $urandom;
        end
        if (!dm_req && !n_dm_req && $urandom_range(99) < pct_dm) begin
          n_dm_req = 1'b1; n_dm_addr = AW'($urandom_range(15)); n_dm_wdata = $urandom;
          n_dm_we = 1'($urandom_range(1));
        end
        if (!if_req && !n_if_req && $urandom_range(99) < pct_if) begin
          n_if_req = 1'b1;
          if ($urandom_range(7) == 0) n_if_addr = AW'($urandom_range(15));
        end
      end

      @(posedge clk1);
      #1;
      rst = n_rst;
      ld_req = n_ld_req; ld_addr = n_ld_addr; ld_wdata = n_ld_wdata;
      dm_req = n_dm_req; dm_addr = n_dm_addr; dm_wdata = n_dm_wdata; dm_we = n_dm_we;
      if_req = n_if_req; if_addr = n_if_addr;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
